// File: rtl/prog_functional_unit.sv
// Programmable state machine whose next state comes from a table of masked-match
// transition rules. The table is loaded through a JTAG-style shadow chain.
module prog_functional_unit #(
  parameter int SW          = 4,
  parameter int XW          = 4,
  parameter int NUM_RULES   = 16,
  parameter int RESET_STATE = 0,
  localparam int RW         = 1 + 2*SW + 2*XW,
  localparam int IW         = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic          clk,
  input  logic          TLR,
  input  logic [XW-1:0] X,
  input  logic          run,
  input  logic          restart,
  input  logic          cfg_shift,
  input  logic          cfg_tdi,
  output logic          cfg_tdo,
  input  logic          cfg_update,
  output logic [SW-1:0] Yin,
  output logic          hit,
  output logic [IW-1:0] rule_idx
);

  localparam int CW = NUM_RULES * RW;

  // Field order matches the chain layout: valid at the MSB, next state at the LSBs.
  typedef struct packed {
    logic          valid;
    logic [SW-1:0] from_st;
    logic [XW-1:0] mask;
    logic [XW-1:0] match_val;
    logic [SW-1:0] nxt;
  } rule_t;

  typedef enum logic [1:0] {
    EV_IDLE,
    EV_RESTART,
    EV_FIRE,
    EV_MISS
  } ev_t;

  logic [CW-1:0]        shadow;
  logic [CW-1:0]        active;
  rule_t                rules    [NUM_RULES];
  logic [NUM_RULES-1:0] rule_hit;
  logic                 any_hit;
  logic [IW-1:0]        win_idx;
  logic [SW-1:0]        win_next;
  ev_t                  ev;

  assign cfg_tdo = shadow[0];

  // Per-rule match: a zero mask bit makes that stimulus bit a don't-care.
  for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule
    assign rules[g]    = rule_t'(active[g*RW +: RW]);
    assign rule_hit[g] = rules[g].valid
                         && (rules[g].from_st == Yin)
                         && ((X & rules[g].mask) == (rules[g].match_val & rules[g].mask));
  end

  // Ascending scan so the highest matching index is the one left standing.
  always_comb begin
    any_hit  = 1'b0;
    win_idx  = '0;
    win_next = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (rule_hit[i]) begin
        any_hit  = 1'b1;
        win_idx  = IW'(i);
        win_next = rules[i].nxt;
      end
    end
  end

  always_comb begin
    ev = EV_IDLE;
    if (restart) begin
      ev = EV_RESTART;
    end else if (run && any_hit) begin
      ev = EV_FIRE;
    end else if (run) begin
      ev = EV_MISS;
    end
  end

  always_ff @(negedge clk or posedge TLR) begin
    if (TLR) begin
      Yin      <= SW'(RESET_STATE);
      hit      <= 1'b0;
      rule_idx <= '0;
    end else begin
      case (ev)
        EV_RESTART: begin
          Yin <= SW'(RESET_STATE);
          hit <= 1'b0;
        end
        EV_FIRE: begin
          Yin      <= win_next;
          hit      <= 1'b1;
          rule_idx <= win_idx;
        end
        default: hit <= 1'b0;
      endcase
    end
  end

  // Shift takes precedence over update; evaluation this edge still sees the old table.
  always_ff @(negedge clk or posedge TLR) begin
    if (TLR) begin
      shadow <= '0;
      active <= '0;
    end else if (cfg_shift) begin
      shadow <= {cfg_tdi, shadow[CW-1:1]};
    end else if (cfg_update) begin
      active <= shadow;
    end
  end

endmodule

// File: tb/tb_prog_functional_unit.sv
// Bench for prog_functional_unit: default instance with a reference model feeding a
// scoreboard queue, plus a wide instance for the parameter sweep.
module tb_prog_functional_unit;

  localparam int CWA = 16 * 17;
  localparam int CWB = 32 * 23;

  logic        clk;
  logic        tlr;
  logic [3:0]  x;
  logic        run, restart, cfg_shift, cfg_tdi, cfg_update;
  logic        cfg_tdo;
  logic [3:0]  yin;
  logic        hit;
  logic [3:0]  rule_idx;

  logic [5:0]  x_b;
  logic        run_b, restart_b, cfg_shift_b, cfg_tdi_b, cfg_update_b;
  logic        cfg_tdo_b;
  logic [4:0]  yin_b;
  logic        hit_b;
  logic [4:0]  rule_idx_b;

  logic [15:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [CWA-1:0] m_active, m_shadow, last_tbl;
  logic [3:0]     m_state, m_idx;
  logic           m_hit;

  prog_functional_unit dut_a (
    .clk(clk), .TLR(tlr), .X(x), .run(run), .restart(restart),
    .cfg_shift(cfg_shift), .cfg_tdi(cfg_tdi), .cfg_tdo(cfg_tdo),
    .cfg_update(cfg_update), .Yin(yin), .hit(hit), .rule_idx(rule_idx)
  );

  prog_functional_unit #(.SW(5), .XW(6), .NUM_RULES(32), .RESET_STATE(31)) dut_b (
    .clk(clk), .TLR(tlr), .X(x_b), .run(run_b), .restart(restart_b),
    .cfg_shift(cfg_shift_b), .cfg_tdi(cfg_tdi_b), .cfg_tdo(cfg_tdo_b),
    .cfg_update(cfg_update_b), .Yin(yin_b), .hit(hit_b), .rule_idx(rule_idx_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [16:0] mk_rule(input logic v, input logic [3:0] f,
                                          input logic [3:0] mask, input logic [3:0] mt,
                                          input logic [3:0] nx);
    return {v, f, mask, mt, nx};
  endfunction

  function automatic logic [22:0] mk_rule_b(input logic v, input logic [4:0] f,
                                            input logic [5:0] mask, input logic [5:0] mt,
                                            input logic [4:0] nx);
    return {v, f, mask, mt, nx};
  endfunction

  // One falling edge on dut_a: model predicts, expectation is queued, then popped.
  task automatic cyc_a(input logic r, input logic rs, input logic [3:0] xv,
                       input logic sh, input logic ti, input logic up);
    logic [16:0] e;
    logic        found;
    logic [3:0]  w, nx;
    logic [15:0] exp_v, got_v;
    run = r; restart = rs; x = xv; cfg_shift = sh; cfg_tdi = ti; cfg_update = up;
    #1;
    checks++;
    if (cfg_tdo !== m_shadow[0]) begin
      errors++;
      $display("FAIL cfg_tdo_model: got %b want %b", cfg_tdo, m_shadow[0]);
    end
    if (rs) begin
      m_state = 4'd0;
      m_hit   = 1'b0;
    end else if (r) begin
      found = 1'b0; w = 4'd0; nx = 4'd0;
      for (int i = 0; i < 16; i++) begin
        e = m_active[i*17 +: 17];
        if (e[16] && e[15:12] == m_state && ((xv & e[11:8]) == (e[7:4] & e[11:8]))) begin
          found = 1'b1; w = 4'(i); nx = e[3:0];
        end
      end
      if (found) begin
        m_state = nx; m_hit = 1'b1; m_idx = w;
      end else begin
        m_hit = 1'b0;
      end
    end else begin
      m_hit = 1'b0;
    end
    if (sh) m_shadow = {ti, m_shadow[CWA-1:1]};
    else if (up) m_active = m_shadow;
    exp_q.push_back({7'd0, m_state, m_hit, m_idx});
    @(negedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got_v = {7'd0, yin, hit, rule_idx};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL scoreboard_a: got yin=%h hit=%b idx=%0d want yin=%h hit=%b idx=%0d",
               yin, hit, rule_idx, exp_v[8:5], exp_v[4], exp_v[3:0]);
    end
  endtask

  task automatic shift_table_a(input logic [CWA-1:0] tbl, input logic r,
                               input logic up_on_last);
    for (int i = 0; i < CWA; i++) begin
      #1;
      checks++;
      if (cfg_tdo !== last_tbl[i]) begin
        errors++;
        $display("FAIL tdo_echo bit %0d: got %b want %b", i, cfg_tdo, last_tbl[i]);
      end
      cyc_a(r, 1'b0, 4'($urandom_range(15, 0)), 1'b1, tbl[i],
            (i == CWA - 1) ? up_on_last : 1'b0);
    end
    last_tbl = tbl;
  endtask

  task automatic load_a(input logic [CWA-1:0] tbl);
    shift_table_a(tbl, 1'b0, 1'b0);
    cyc_a(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load_b(input logic [CWB-1:0] tbl);
    run_b = 1'b0; restart_b = 1'b0; cfg_update_b = 1'b0;
    for (int i = 0; i < CWB; i++) begin
      cfg_shift_b = 1'b1; cfg_tdi_b = tbl[i];
      @(negedge clk);
      #1;
    end
    cfg_shift_b = 1'b0; cfg_update_b = 1'b1;
    @(negedge clk);
    #1;
    cfg_update_b = 1'b0;
  endtask

  task automatic step_b(input logic r, input logic rs, input logic [5:0] xv,
                        input logic [4:0] ey, input logic eh, input logic [4:0] ei);
    logic [15:0] exp_v, got_v;
    run_b = r; restart_b = rs; x_b = xv;
    exp_q.push_back({5'd0, ey, eh, ei});
    @(negedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got_v = {5'd0, yin_b, hit_b, rule_idx_b};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL scoreboard_b: got yin=%0d hit=%b idx=%0d want yin=%0d hit=%b idx=%0d",
               yin_b, hit_b, rule_idx_b, exp_v[10:6], exp_v[5], exp_v[4:0]);
    end
  endtask

  task automatic test_reset;
    logic [CWA-1:0] tbl;
    checks++;
    if ({yin, hit, rule_idx, cfg_tdo} !== 10'd0) begin
      errors++;
      $display("FAIL por_state: got yin=%h hit=%b idx=%0d tdo=%b want all 0",
               yin, hit, rule_idx, cfg_tdo);
    end
    tbl = '0;
    tbl[0 +: 17] = mk_rule(1'b1, 4'h0, 4'h0, 4'h0, 4'h9);
    load_a(tbl);
    cyc_a(1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'h9) begin
      errors++;
      $display("FAIL reach_9: got %h want 9", yin);
    end
    @(posedge clk);
    #2;
    tlr = 1'b1;
    #1;
    checks++;
    if (yin !== 4'h0 || hit !== 1'b0 || rule_idx !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: got yin=%h hit=%b idx=%0d want 0/0/0", yin, hit, rule_idx);
    end
    m_state = 4'd0; m_hit = 1'b0; m_idx = 4'd0; m_active = '0; m_shadow = '0; last_tbl = '0;
    #1;
    tlr = 1'b0;
    @(negedge clk);
    #1;
    for (int i = 0; i < 10; i++) cyc_a(1'b1, 1'b0, 4'($urandom_range(15, 0)), 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'h0 || hit !== 1'b0) begin
      errors++;
      $display("FAIL empty_table: got yin=%h hit=%b want 0/0", yin, hit);
    end
  endtask

  task automatic test_load_match;
    logic [CWA-1:0] tbl;
    tbl = '0;
    tbl[0*17 +: 17] = mk_rule(1'b1, 4'h0, 4'hF, 4'h2, 4'h1);
    tbl[1*17 +: 17] = mk_rule(1'b1, 4'h0, 4'hD, 4'h8, 4'h6);
    tbl[2*17 +: 17] = mk_rule(1'b1, 4'h0, 4'hF, 4'hF, 4'hD);
    load_a(tbl);
    cyc_a(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'h1 || hit !== 1'b1 || rule_idx !== 4'd0) begin
      errors++;
      $display("FAIL match_r0: got yin=%h hit=%b idx=%0d want 1/1/0", yin, hit, rule_idx);
    end
    cyc_a(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'h6 || rule_idx !== 4'd1) begin
      errors++;
      $display("FAIL match_r1: got yin=%h idx=%0d want 6/1", yin, rule_idx);
    end
    cyc_a(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'hD || rule_idx !== 4'd2) begin
      errors++;
      $display("FAIL match_r2: got yin=%h idx=%0d want D/2", yin, rule_idx);
    end
  endtask

  task automatic test_priority;
    logic [CWA-1:0] tbl;
    tbl = last_tbl;
    tbl[3*17 +: 17] = mk_rule(1'b1, 4'h1, 4'h0, 4'h0, 4'h3);
    tbl[4*17 +: 17] = mk_rule(1'b1, 4'h1, 4'hF, 4'h2, 4'hB);
    load_a(tbl);
    cyc_a(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'hB || rule_idx !== 4'd4) begin
      errors++;
      $display("FAIL prio_r4: got yin=%h idx=%0d want B/4", yin, rule_idx);
    end
    cyc_a(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'h3 || rule_idx !== 4'd3) begin
      errors++;
      $display("FAIL prio_r3: got yin=%h idx=%0d want 3/3", yin, rule_idx);
    end
  endtask

  task automatic test_no_match;
    logic [CWA-1:0] tbl;
    tbl = last_tbl;
    tbl[3*17 +: 17] = mk_rule(1'b0, 4'h1, 4'h0, 4'h0, 4'h3);
    load_a(tbl);
    cyc_a(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'h1 || hit !== 1'b0 || rule_idx !== 4'd0) begin
      errors++;
      $display("FAIL no_match_hold: got yin=%h hit=%b idx=%0d want 1/0/0", yin, hit, rule_idx);
    end
    cyc_a(1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'h1 || hit !== 1'b0) begin
      errors++;
      $display("FAIL run0_hold: got yin=%h hit=%b want 1/0", yin, hit);
    end
  endtask

  task automatic test_shift_update;
    logic [CWA-1:0] tbl;
    tbl = '0;
    tbl[0*17 +: 17] = mk_rule(1'b1, 4'h0, 4'h0, 4'h0, 4'h7);
    tbl[1*17 +: 17] = mk_rule(1'b1, 4'h7, 4'h0, 4'h0, 4'h0);
    cyc_a(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    shift_table_a(tbl, 1'b1, 1'b1);
    cyc_a(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'h1) begin
      errors++;
      $display("FAIL update_shift_ignored: got %h want 1", yin);
    end
    cyc_a(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1);
    checks++;
    if (yin !== 4'h1 || rule_idx !== 4'd0) begin
      errors++;
      $display("FAIL update_edge_old_table: got yin=%h idx=%0d want 1/0", yin, rule_idx);
    end
    cyc_a(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'h7 || hit !== 1'b1 || rule_idx !== 4'd0) begin
      errors++;
      $display("FAIL new_table: got yin=%h hit=%b idx=%0d want 7/1/0", yin, hit, rule_idx);
    end
    cyc_a(1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0);
    checks++;
    if (yin !== 4'h0 || rule_idx !== 4'd1) begin
      errors++;
      $display("FAIL new_table_r1: got yin=%h idx=%0d want 0/1", yin, rule_idx);
    end
  endtask

  task automatic test_param_sweep;
    logic [CWB-1:0] tbl;
    tbl = '0;
    tbl[0 +: 23] = mk_rule_b(1'b1, 5'd31, 6'h3F, 6'h2A, 5'd17);
    load_b(tbl);
    step_b(1'b1, 1'b0, 6'h2B, 5'd31, 1'b0, 5'd0);
    step_b(1'b1, 1'b0, 6'h2A, 5'd17, 1'b1, 5'd0);
    step_b(1'b0, 1'b1, 6'h00, 5'd31, 1'b0, 5'd0);
    tbl[31*23 +: 23] = mk_rule_b(1'b1, 5'd31, 6'h00, 6'h00, 5'd5);
    load_b(tbl);
    step_b(1'b1, 1'b0, 6'h2A, 5'd5, 1'b1, 5'd31);
  endtask

  initial begin
    tlr = 1'b1;
    x = '0; run = 1'b0; restart = 1'b0; cfg_shift = 1'b0; cfg_tdi = 1'b0; cfg_update = 1'b0;
    x_b = '0; run_b = 1'b0; restart_b = 1'b0; cfg_shift_b = 1'b0; cfg_tdi_b = 1'b0;
    cfg_update_b = 1'b0;
    m_state = 4'd0; m_hit = 1'b0; m_idx = 4'd0; m_active = '0; m_shadow = '0; last_tbl = '0;
    repeat (2) @(negedge clk);
    #1;
    tlr = 1'b0;
    test_reset();
    test_load_match();
    test_priority();
    test_no_match();
    test_shift_update();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
